bpi_flash_seq: RTL and testbench
================================

# bpi_flash_seq

Command sequencer that sits directly upstream of the BPI flash controller and turns high-level requests (burst read, word program, block erase, block unlock) into the controller's word-level read/write streams. It drives the controller's `mode` input. It issues CFI/Intel command-set words (0x00FF, 0x0040, 0x0020, 0x00D0, 0x0060, 0x0050). It polls the status register until ready, then returns read data on an output stream and a completion status.

## Interface
- `C_MEM_WIDTH`, 16: flash data width.
- `C_ADDR_WIDTH`, 26: word address width; matches the controller's address ports.
- `C_LEN_WIDTH`, 16: burst length field width.
- `C_POLL_LIMIT`, 1048576: maximum status reads per operation before timeout.

Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high. Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `s_cmd_op`  in  2  0 = read burst, 1 = program word, 2 = erase block, 3 = unlock block.
- `s_cmd_addr`  in  C_ADDR_WIDTH  start word address or block address.
- `s_cmd_len`  in  C_LEN_WIDTH  number of read words minus 1 (op 0 only).
- `s_cmd_data`  in  C_MEM_WIDTH  word to program (op 1 only).
- `s_cmd_valid` / `s_cmd_ready`  in/out  1  command handshake.
- `m_axis_data_tdata`  out  C_MEM_WIDTH  read data; no tready.
- `m_axis_data_tvalid`, `m_axis_data_tlast`  out  1 each  read data valid; last word of burst.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`.
- `status`  out  8  last status register value, valid with `done`.
- `ctrl_mode`  out  1  to controller `mode`: 0 = read, 1 = write.
- `m_axis_rd_tdata`  out  C_ADDR_WIDTH  read address to controller.
- `m_axis_rd_tvalid` / `m_axis_rd_tready`  out/in  1  read address handshake.
- `s_axis_rd_tdata`, `s_axis_rd_tvalid`  in  C_MEM_WIDTH, 1  read data from controller.
- `m_axis_wr_tdata`, `m_axis_wr_tdest`  out  C_MEM_WIDTH, C_ADDR_WIDTH  write word and address.
- `m_axis_wr_tvalid` / `m_axis_wr_tready`  out/in  1  write handshake.

## Operation
- States: IDLE, WR_STEP, RD_ISSUE, RD_DRAIN, POLL_ISSUE, POLL_WAIT, CLEAR, FINISH.
- IDLE: `s_cmd_ready`=1. On handshake, latch op/addr/len/data, set step index 0 and go to WR_STEP.
- Write-step lists (all to the latched addr): read = {0x00FF}; program = {0x0040, data}; erase = {0x0020, 0x00D0}; unlock = {0x0060, 0x00D0, 0x00FF}.
- WR_STEP: `ctrl_mode`=1 and assert `m_axis_wr_tvalid` with the current step word. On wr handshake, drop tvalid and advance the step. After the last step, go to RD_ISSUE (read), POLL_ISSUE (program/erase) or FINISH (unlock).
- `ctrl_mode` changes only while neither valid is asserted, and at least 1 cycle before the next valid asserts.
- RD_ISSUE: `ctrl_mode`=0. Hold `m_axis_rd_tvalid`=1 continuously and increment the address on each handshake, so the controller keeps CE/OE low across the burst. After len+1 accepted addresses, drop tvalid and go to RD_DRAIN.
- Read data: each `s_axis_rd_tvalid` word is forwarded to `m_axis_data` the next cycle. A return counter sets `tlast` on word len+1. RD_DRAIN waits for that word, then goes to FINISH with `error`=0.
- POLL_ISSUE/POLL_WAIT: issue a single-address read and capture the returned word's low byte into `status`.
  - If SR7=0 and the poll count is below C_POLL_LIMIT, re-issue the read.
  - If SR7=1: error = |SR[5:1].
  - If the poll count reaches C_POLL_LIMIT: error = 1 (timeout).
- CLEAR: entered whenever error=1 or the op was program/erase. Writes 0x0050 (only if error) and then 0x00FF, then goes to FINISH.
- FINISH: pulse `done` for one cycle with `error`/`status`, then return to IDLE.
- Poll data is never forwarded to `m_axis_data`.

## Timing
- Reset values: `s_cmd_ready`=0 and all valids, `tlast`, `done`, `error`, `ctrl_mode`, `status` = 0. All address/data outputs = 0.
- `s_cmd_ready` rises the first cycle after reset deasserts.
- `s_cmd_ready` is 0 from the cycle after the command handshake until the cycle after `done`.
- `m_axis_data` latency is 1 cycle from `s_axis_rd_tvalid`. There is no backpressure.
- Valids, once asserted, stay high with stable payload until their handshake. The burst read address is the exception: its payload advances on each handshake.
- Reset mid-operation: all outputs return to reset values on the next edge and no `done` is produced. The controller shares `rst` (inverted to its `rst_n`).
- len = max (2^C_LEN_WIDTH words): the word counter is C_LEN_WIDTH+1 bits and does not wrap.
- The address increments modulo 2^C_ADDR_WIDTH.

## Test plan
- Read op 0, addr 0x100, len 3, model returns addr^0xA5A5:
  - write (0x100, 0x00FF);
  - addresses 0x100–0x103 issued back-to-back with tvalid held high;
  - 4 data words out, tlast on the 4th;
  - `done`, `error`=0.
- Program op 1, addr 0x20, data 0x1234, status returns 0x00 twice then 0x80:
  - writes 0x0040, 0x1234;
  - 3 polls;
  - write 0x00FF;
  - `done`, `status`=0x80, `error`=0.
- Erase with status 0xA0 (SR5 erase fail):
  - writes 0x0020, 0x00D0, 0x0050, 0x00FF;
  - `error`=1, `status`=0xA0.
- Timeout with C_POLL_LIMIT=4 and status stuck at 0x00:
  - exactly 4 polls;
  - writes 0x0050, 0x00FF;
  - `error`=1.
- Unlock op 3, addr 0x4000: writes 0x0060, 0x00D0, 0x00FF; no reads; `done`, `error`=0.
- `rst` asserted mid-burst after 2 of 8 addresses: next cycle all valids=0 and `s_cmd_ready`=0; no `done`. A new read afterwards completes normally.

Source files
------------

// File: rtl/bpi_flash_seq_if.sv
// Bundles the command port, read-data stream and flash-controller streams of bpi_flash_seq.
// The master modport is the sequencer's view; slave is the command source / controller view.
interface bpi_flash_seq_if #(
  parameter int C_MEM_WIDTH  = 16,
  parameter int C_ADDR_WIDTH = 26,
  parameter int C_LEN_WIDTH  = 16
);
  logic [1:0]              s_cmd_op;
  logic [C_ADDR_WIDTH-1:0] s_cmd_addr;
  logic [C_LEN_WIDTH-1:0]  s_cmd_len;
  logic [C_MEM_WIDTH-1:0]  s_cmd_data;
  logic                    s_cmd_valid;
  logic                    s_cmd_ready;
  logic [C_MEM_WIDTH-1:0]  m_axis_data_tdata;
  logic                    m_axis_data_tvalid;
  logic                    m_axis_data_tlast;
  logic                    done;
  logic                    error;
  logic [7:0]              status;
  logic                    ctrl_mode;
  logic [C_ADDR_WIDTH-1:0] m_axis_rd_tdata;
  logic                    m_axis_rd_tvalid;
  logic                    m_axis_rd_tready;
  logic [C_MEM_WIDTH-1:0]  s_axis_rd_tdata;
  logic                    s_axis_rd_tvalid;
  logic [C_MEM_WIDTH-1:0]  m_axis_wr_tdata;
  logic [C_ADDR_WIDTH-1:0] m_axis_wr_tdest;
  logic                    m_axis_wr_tvalid;
  logic                    m_axis_wr_tready;

  modport master (
    input  s_cmd_op, s_cmd_addr, s_cmd_len, s_cmd_data, s_cmd_valid,
    output s_cmd_ready,
    output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    output done, error, status, ctrl_mode,
    output m_axis_rd_tdata, m_axis_rd_tvalid,
    input  m_axis_rd_tready,
    input  s_axis_rd_tdata, s_axis_rd_tvalid,
    output m_axis_wr_tdata, m_axis_wr_tdest, m_axis_wr_tvalid,
    input  m_axis_wr_tready
  );

  modport slave (
    output s_cmd_op, s_cmd_addr, s_cmd_len, s_cmd_data, s_cmd_valid,
    input  s_cmd_ready,
    input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    input  done, error, status, ctrl_mode,
    input  m_axis_rd_tdata, m_axis_rd_tvalid,
    output m_axis_rd_tready,
    output s_axis_rd_tdata, s_axis_rd_tvalid,
    input  m_axis_wr_tdata, m_axis_wr_tdest, m_axis_wr_tvalid,
    output m_axis_wr_tready
  );
endinterface

// File: rtl/bpi_flash_seq.sv
// BPI flash command sequencer: expands read/program/erase/unlock requests into controller
// word streams, polls SR7 for completion and reports done/error/status.
// state      | meaning
// IDLE       | accepting a command
// WR_STEP    | writing the op's command words (ctrl_mode=1)
// RD_ISSUE   | streaming burst read addresses, tvalid held high
// RD_DRAIN   | waiting for the last burst word
// POLL_ISSUE | issuing one status read
// POLL_WAIT  | waiting for the status word
// CLEAR      | optional 0x0050 then 0x00FF back to read-array
// FINISH     | one-cycle done pulse
module bpi_flash_seq #(
  parameter int C_MEM_WIDTH  = 16,
  parameter int C_ADDR_WIDTH = 26,
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_POLL_LIMIT = 1048576
) (
  input logic            clk,
  input logic            rst,
  bpi_flash_seq_if.master bus
);
  localparam int PW = $clog2(C_POLL_LIMIT + 1);
  localparam logic [C_MEM_WIDTH-1:0] W_FF = C_MEM_WIDTH'('h00FF);
  localparam logic [C_MEM_WIDTH-1:0] W_40 = C_MEM_WIDTH'('h0040);
  localparam logic [C_MEM_WIDTH-1:0] W_20 = C_MEM_WIDTH'('h0020);
  localparam logic [C_MEM_WIDTH-1:0] W_D0 = C_MEM_WIDTH'('h00D0);
  localparam logic [C_MEM_WIDTH-1:0] W_60 = C_MEM_WIDTH'('h0060);
  localparam logic [C_MEM_WIDTH-1:0] W_50 = C_MEM_WIDTH'('h0050);

  typedef enum logic [2:0] {
    IDLE, WR_STEP, RD_ISSUE, RD_DRAIN, POLL_ISSUE, POLL_WAIT, CLEAR, FINISH
  } state_t;

  state_t                  state, state_nxt;
  logic                    rdy_q, mode_q, wr_vld_q, rd_vld_q, error_q;
  logic [1:0]              op_q, step_q;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_LEN_WIDTH-1:0]  len_q;
  logic [C_MEM_WIDTH-1:0]  data_q, wr_dat_q, dout_q;
  logic                    dout_vld_q, dout_last_q;
  logic [C_LEN_WIDTH:0]    iss_cnt, ret_cnt;
  logic [PW-1:0]           poll_cnt;
  logic [7:0]              status_q;

  logic                    cmd_fire, wr_fire, rd_fire, iss_last, ret_last;
  logic                    step_last, poll_end, poll_err, at_limit, in_burst;
  logic [7:0]              sr;
  logic [C_MEM_WIDTH-1:0]  step_word, clr_word;

  assign cmd_fire = bus.s_cmd_valid & rdy_q;
  assign wr_fire  = wr_vld_q & bus.m_axis_wr_tready;
  assign rd_fire  = rd_vld_q & bus.m_axis_rd_tready;
  assign iss_last = (iss_cnt == {1'b0, len_q});
  assign ret_last = (ret_cnt == {1'b0, len_q});
  assign in_burst = (state == RD_ISSUE) || (state == RD_DRAIN);
  assign sr       = bus.s_axis_rd_tdata[7:0];
  assign at_limit = (poll_cnt == PW'(C_POLL_LIMIT));
  assign poll_end = sr[7] | at_limit;
  // SR7 wins over the limit: a ready status on the last allowed poll is not a timeout
  assign poll_err = sr[7] ? (|sr[5:1]) : 1'b1;
  assign clr_word = (step_q == 2'd0) ? W_50 : W_FF;

  always_comb begin
    step_word = W_FF;
    step_last = (step_q == 2'd1);
    case (op_q)
      2'd0: step_last = (step_q == 2'd0);
      2'd1: step_word = (step_q == 2'd0) ? W_40 : data_q;
      2'd2: step_word = (step_q == 2'd0) ? W_20 : W_D0;
      default: begin
        step_word = (step_q == 2'd0) ? W_60 : (step_q == 2'd1) ? W_D0 : W_FF;
        step_last = (step_q == 2'd2);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cmd_fire) state_nxt = WR_STEP;
      WR_STEP:    if (wr_fire && step_last)
                    state_nxt = (op_q == 2'd0) ? RD_ISSUE :
                                (op_q == 2'd3) ? FINISH : POLL_ISSUE;
      RD_ISSUE:   if (rd_fire && iss_last) state_nxt = RD_DRAIN;
      RD_DRAIN:   if (bus.s_axis_rd_tvalid && ret_last) state_nxt = FINISH;
      POLL_ISSUE: if (rd_fire) state_nxt = POLL_WAIT;
      POLL_WAIT:  if (bus.s_axis_rd_tvalid) state_nxt = poll_end ? CLEAR : POLL_ISSUE;
      CLEAR:      if (wr_fire && step_q == 2'd1) state_nxt = FINISH;
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;  mode_q <= 1'b0;  wr_vld_q <= 1'b0;  rd_vld_q <= 1'b0;
      error_q <= 1'b0;  op_q <= '0;  step_q <= '0;  addr_q <= '0;  len_q <= '0;
      data_q <= '0;  wr_dat_q <= '0;  dout_q <= '0;  dout_vld_q <= 1'b0;
      dout_last_q <= 1'b0;  iss_cnt <= '0;  ret_cnt <= '0;  poll_cnt <= '0;
      status_q <= '0;
    end else begin
      rdy_q       <= (state_nxt == IDLE);
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      case (state)
        IDLE: if (cmd_fire) begin
          op_q     <= bus.s_cmd_op;
          addr_q   <= bus.s_cmd_addr;
          len_q    <= bus.s_cmd_len;
          data_q   <= bus.s_cmd_data;
          step_q   <= '0;
          iss_cnt  <= '0;
          ret_cnt  <= '0;
          poll_cnt <= '0;
          error_q  <= 1'b0;
          status_q <= '0;
        end
        // mode flips a full cycle before any valid is raised on the new stream
        WR_STEP, CLEAR: begin
          if (!mode_q) mode_q <= 1'b1;
          else if (wr_fire) begin
            wr_vld_q <= 1'b0;
            step_q   <= step_q + 2'd1;
          end else if (!wr_vld_q) begin
            wr_vld_q <= 1'b1;
            wr_dat_q <= (state == CLEAR) ? clr_word : step_word;
          end
        end
        RD_ISSUE, POLL_ISSUE: begin
          if (mode_q) mode_q <= 1'b0;
          else if (rd_fire) begin
            if (state == POLL_ISSUE) begin
              rd_vld_q <= 1'b0;
              poll_cnt <= poll_cnt + PW'(1);
            end else begin
              addr_q  <= addr_q + C_ADDR_WIDTH'(1);
              iss_cnt <= iss_cnt + (C_LEN_WIDTH + 1)'(1);
              if (iss_last) rd_vld_q <= 1'b0;
            end
          end else if (!rd_vld_q) rd_vld_q <= 1'b1;
        end
        POLL_WAIT: if (bus.s_axis_rd_tvalid) begin
          status_q <= sr;
          if (poll_end) begin
            error_q <= poll_err;
            step_q  <= poll_err ? 2'd0 : 2'd1;
          end
        end
        default: ;
      endcase
      if (in_burst && bus.s_axis_rd_tvalid) begin
        dout_q      <= bus.s_axis_rd_tdata;
        dout_vld_q  <= 1'b1;
        dout_last_q <= ret_last;
        ret_cnt     <= ret_cnt + (C_LEN_WIDTH + 1)'(1);
      end
    end
  end

  assign bus.s_cmd_ready        = rdy_q;
  assign bus.ctrl_mode          = mode_q;
  assign bus.m_axis_wr_tvalid   = wr_vld_q;
  assign bus.m_axis_wr_tdata    = wr_dat_q;
  assign bus.m_axis_wr_tdest    = addr_q;
  assign bus.m_axis_rd_tvalid   = rd_vld_q;
  assign bus.m_axis_rd_tdata    = addr_q;
  assign bus.m_axis_data_tdata  = dout_q;
  assign bus.m_axis_data_tvalid = dout_vld_q;
  assign bus.m_axis_data_tlast  = dout_last_q;
  assign bus.done               = (state == FINISH);
  assign bus.error              = error_q;
  assign bus.status             = status_q;
endmodule

// File: tb/tb_bpi_flash_seq.sv
// Directed bench for bpi_flash_seq with a one-cycle-latency flash controller model.
module tb_bpi_flash_seq;
  localparam int MW = 16, AW = 26, LW = 16, PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpi_flash_seq_if #(.C_MEM_WIDTH(MW), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) bus ();
  bpi_flash_seq #(.C_MEM_WIDTH(MW), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW), .C_POLL_LIMIT(PL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // controller model state
  bit          poll_mode = 1'b0;
  logic [7:0]  st_list[$];
  int          st_idx = 0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;

  always @(negedge clk) begin
    int k;
    bus.s_axis_rd_tvalid = pend_v;
    bus.s_axis_rd_tdata  = pend_d;
    pend_v = bus.m_axis_rd_tvalid && bus.m_axis_rd_tready;
    if (pend_v) begin
      if (poll_mode && st_list.size() > 0) begin
        k = (st_idx < st_list.size() - 1) ? st_idx : st_list.size() - 1;
        pend_d = {8'h00, st_list[k]};
        st_idx++;
      end else begin
        pend_d = bus.m_axis_rd_tdata[15:0] ^ 16'hA5A5;
      end
    end
  end

  // monitor logs
  logic [15:0] wr_w[$];
  logic [25:0] wr_d[$];
  logic [25:0] rd_a[$];
  int          rd_c[$];
  logic [15:0] dq[$];
  logic        lq[$];
  int          done_cnt = 0, mode_bad = 0, cyc = 0;
  logic        prev_mode = 1'b0;

  always @(negedge clk) begin
    if (bus.m_axis_wr_tvalid && bus.m_axis_wr_tready) begin
      wr_w.push_back(bus.m_axis_wr_tdata);
      wr_d.push_back(bus.m_axis_wr_tdest);
    end
    if (bus.m_axis_rd_tvalid && bus.m_axis_rd_tready) begin
      rd_a.push_back(bus.m_axis_rd_tdata);
      rd_c.push_back(cyc);
    end
    if (bus.m_axis_data_tvalid) begin
      dq.push_back(bus.m_axis_data_tdata);
      lq.push_back(bus.m_axis_data_tlast);
    end
    if (bus.done) done_cnt++;
    if (bus.ctrl_mode !== prev_mode && (bus.m_axis_wr_tvalid || bus.m_axis_rd_tvalid))
      mode_bad++;
    prev_mode = bus.ctrl_mode;
    cyc++;
  end

  logic       got_err;
  logic [7:0] got_st;

  task automatic clear_logs();
    wr_w.delete(); wr_d.delete(); rd_a.delete(); rd_c.delete(); dq.delete(); lq.delete();
    st_idx = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [25:0] addr,
                          input logic [15:0] len, input logic [15:0] data);
    int t = 0;
    bus.s_cmd_op = op; bus.s_cmd_addr = addr; bus.s_cmd_len = len; bus.s_cmd_data = data;
    bus.s_cmd_valid = 1'b1;
    while (!bus.s_cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_accept", 32'(t < 50), 1);
    @(negedge clk);
    bus.s_cmd_valid = 1'b0;
    chk("ready_low_busy", bus.s_cmd_ready, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 500) begin @(negedge clk); t++; end
    chk("done_seen", bus.done, 1);
    got_err = bus.error;
    got_st  = bus.status;
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("ready_after_done", bus.s_cmd_ready, 1);
  endtask

  initial begin
    int n, t, dc0;
    bus.s_cmd_op = '0; bus.s_cmd_addr = '0; bus.s_cmd_len = '0; bus.s_cmd_data = '0;
    bus.s_cmd_valid = 1'b0; bus.m_axis_rd_tready = 1'b1; bus.m_axis_wr_tready = 1'b1;
    bus.s_axis_rd_tvalid = 1'b0; bus.s_axis_rd_tdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.s_cmd_ready, 0);
    chk("rst_valids", {bus.m_axis_wr_tvalid, bus.m_axis_rd_tvalid, bus.m_axis_data_tvalid}, 0);
    chk("rst_flags", {bus.done, bus.error, bus.ctrl_mode, bus.m_axis_data_tlast}, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_addr", bus.m_axis_rd_tdata, 0);
    chk("rst_wdata", bus.m_axis_wr_tdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rise", bus.s_cmd_ready, 1);

    // burst read 0x100 len 3
    clear_logs(); poll_mode = 1'b0;
    send_cmd(2'd0, 26'h100, 16'd3, 16'h0);
    wait_done();
    chk("rd_err", got_err, 0);
    chk("rd_nwr", wr_w.size(), 1);
    chk("rd_wr0", wr_w[0], 16'h00FF);
    chk("rd_dest0", wr_d[0], 26'h100);
    chk("rd_naddr", rd_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("rd_addr", rd_a[i], 26'h100 + 26'(i));
    chk("rd_b2b", rd_c[3] - rd_c[0], 3);
    chk("rd_ndata", dq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd_data", dq[i], (16'h0100 + 16'(i)) ^ 16'hA5A5);
      chk("rd_last", lq[i], 32'(i == 3));
    end

    // program 0x20 <- 0x1234, ready on the third poll
    clear_logs(); poll_mode = 1'b1; st_list = '{8'h00, 8'h00, 8'h80};
    send_cmd(2'd1, 26'h20, 16'd0, 16'h1234);
    wait_done();
    chk("pg_err", got_err, 0);
    chk("pg_status", got_st, 8'h80);
    chk("pg_nwr", wr_w.size(), 3);
    chk("pg_wr0", wr_w[0], 16'h0040);
    chk("pg_wr1", wr_w[1], 16'h1234);
    chk("pg_wr2", wr_w[2], 16'h00FF);
    chk("pg_dest", wr_d[1], 26'h20);
    chk("pg_polls", rd_a.size(), 3);
    chk("pg_poll_addr", rd_a[2], 26'h20);
    chk("pg_no_data", dq.size(), 0);

    // erase 0x3000 with erase failure status
    clear_logs(); poll_mode = 1'b1; st_list = '{8'hA0};
    send_cmd(2'd2, 26'h3000, 16'd0, 16'h0);
    wait_done();
    chk("er_err", got_err, 1);
    chk("er_status", got_st, 8'hA0);
    chk("er_nwr", wr_w.size(), 4);
    chk("er_wr0", wr_w[0], 16'h0020);
    chk("er_wr1", wr_w[1], 16'h00D0);
    chk("er_wr2", wr_w[2], 16'h0050);
    chk("er_wr3", wr_w[3], 16'h00FF);
    chk("er_polls", rd_a.size(), 1);

    // program with status stuck busy: times out after exactly 4 polls
    clear_logs(); poll_mode = 1'b1; st_list = '{8'h00};
    send_cmd(2'd1, 26'h40, 16'd0, 16'hBEEF);
    wait_done();
    chk("to_err", got_err, 1);
    chk("to_status", got_st, 8'h00);
    chk("to_polls", rd_a.size(), 4);
    chk("to_nwr", wr_w.size(), 4);
    chk("to_wr1", wr_w[1], 16'hBEEF);
    chk("to_wr2", wr_w[2], 16'h0050);
    chk("to_wr3", wr_w[3], 16'h00FF);

    // unlock 0x4000
    clear_logs(); poll_mode = 1'b0;
    send_cmd(2'd3, 26'h4000, 16'd0, 16'h0);
    wait_done();
    chk("ul_err", got_err, 0);
    chk("ul_nwr", wr_w.size(), 3);
    chk("ul_wr0", wr_w[0], 16'h0060);
    chk("ul_wr1", wr_w[1], 16'h00D0);
    chk("ul_wr2", wr_w[2], 16'h00FF);
    chk("ul_dest", wr_d[2], 26'h4000);
    chk("ul_reads", rd_a.size(), 0);

    // reset mid-burst after 2 of 8 addresses
    clear_logs(); poll_mode = 1'b0; dc0 = done_cnt;
    send_cmd(2'd0, 26'h200, 16'd7, 16'h0);
    n = 0; t = 0;
    while (n < 2 && t < 200) begin
      if (bus.m_axis_rd_tvalid && bus.m_axis_rd_tready) n++;
      if (n < 2) begin @(negedge clk); t++; end
    end
    chk("mid_two_addr", n, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valids", {bus.m_axis_wr_tvalid, bus.m_axis_rd_tvalid, bus.m_axis_data_tvalid}, 0);
    chk("mid_ready", bus.s_cmd_ready, 0);
    chk("mid_flags", {bus.done, bus.ctrl_mode, bus.error}, 0);
    chk("mid_addr", bus.m_axis_rd_tdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_no_done", done_cnt - dc0, 0);
    clear_logs();
    send_cmd(2'd0, 26'h300, 16'd1, 16'h0);
    wait_done();
    chk("post_err", got_err, 0);
    chk("post_ndata", dq.size(), 2);
    chk("post_d0", dq[0], 16'hA6A5);
    chk("post_d1", dq[1], 16'hA6A4);
    chk("post_last", {lq[0], lq[1]}, 2'b01);
    chk("post_done_cnt", done_cnt - dc0, 1);

    chk("mode_rule", mode_bad, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
